ibex_instr_realigner: RTL

IBEX_INSTR_REALIGNER -- requirements
Module: ibex_instr_realigner

---
 rtl/ibex_pkg.sv | 19 +
 rtl/ibex_instr_realigner.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/ibex_pkg.sv
// ibex_pkg: shared definitions for the instruction realigner.
//   INSTR_UNCOMPRESSED : value of instr[1:0] that marks a 32-bit instruction.
//   realign_stash_t    : one held halfword with its PC and fetch error flag.
//   is_compressed()    : true when a halfword starts a 16-bit instruction.
package ibex_pkg;

    localparam logic [1:0] INSTR_UNCOMPRESSED = 2'b11;

    typedef struct packed {
        logic [15:0] half;
        logic [31:0] addr;
        logic        err;
    } realign_stash_t;

    function automatic logic is_compressed(input logic [15:0] h);
        return h[1:0] != INSTR_UNCOMPRESSED;
    endfunction

endpackage

// File: rtl/ibex_instr_realigner.sv
// ibex_instr_realigner: turns a stream of 32-bit fetch words into aligned
// 16/32-bit instructions using a single halfword stash.
// Ports:
//   clk_i, rst_ni             clock, async active-low reset
//   clear_i                   branch/flush, drops held state
//   in_valid_i/in_ready_o     fetch word handshake (in_rdata_i, in_addr_i, in_err_i)
//   out_valid_o/out_ready_i   instruction handshake
//   out_instr_o, out_addr_o   instruction (compressed ones zero-extended) and PC
//   out_is_compressed_o       out_instr_o is a 16-bit instruction
//   out_err_o, out_err_plus2_o fetch error, and whether it belongs to PC+2 only
module ibex_instr_realigner #(
    parameter bit ResetAll = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_rdata_i,
    input  logic [31:0] in_addr_i,
    input  logic        in_err_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_instr_o,
    output logic [31:0] out_addr_o,
    output logic        out_is_compressed_o,
    output logic        out_err_o,
    output logic        out_err_plus2_o
);
    import ibex_pkg::*;

    logic           stash_valid_q, stash_valid_d;
    realign_stash_t stash_q, stash_d;

    logic [15:0] in_lo, in_hi;
    logic [31:0] in_addr_p2;

    assign in_lo      = in_rdata_i[15:0];
    assign in_hi      = in_rdata_i[31:16];
    assign in_addr_p2 = in_addr_i + 32'd2;

    always_comb begin
        out_valid_o     = 1'b0;
        in_ready_o      = 1'b0;
        out_instr_o     = '0;
        out_addr_o      = '0;
        out_err_o       = 1'b0;
        out_err_plus2_o = 1'b0;
        stash_valid_d   = stash_valid_q;
        stash_d         = stash_q;

        if (stash_valid_q) begin
            out_addr_o = stash_q.addr;
            if (is_compressed(stash_q.half)) begin
                // Held compressed instruction drains without touching the input word.
                out_valid_o = 1'b1;
                out_instr_o = {16'h0000, stash_q.half};
                out_err_o   = stash_q.err;
                if (out_ready_i) begin
                    stash_valid_d = 1'b0;
                end
            end else begin
                // Upper half of a split instruction comes from the next word.
                out_valid_o     = in_valid_i;
                out_instr_o     = {in_lo, stash_q.half};
                out_err_o       = stash_q.err | in_err_i;
                out_err_plus2_o = in_err_i & ~stash_q.err;
                if (in_valid_i && out_ready_i) begin
                    in_ready_o = 1'b1;
                    if (in_err_i || stash_q.err) begin
                        stash_valid_d = 1'b0;
                    end else begin
                        stash_valid_d = 1'b1;
                        stash_d       = '{half: in_hi, addr: in_addr_p2, err: 1'b0};
                    end
                end
            end
        end else if (in_valid_i) begin
            out_addr_o = in_addr_i;
            if (in_err_i) begin
                // Whole faulting word becomes one error instruction.
                out_valid_o = 1'b1;
                out_instr_o = in_addr_i[1] ? {16'h0000, in_hi} : in_rdata_i;
                out_err_o   = 1'b1;
                in_ready_o  = out_ready_i;
            end else if (!in_addr_i[1]) begin
                out_valid_o = 1'b1;
                if (is_compressed(in_lo)) begin
                    out_instr_o = {16'h0000, in_lo};
                    if (out_ready_i) begin
                        in_ready_o    = 1'b1;
                        stash_valid_d = 1'b1;
                        stash_d       = '{half: in_hi, addr: in_addr_p2, err: 1'b0};
                    end
                end else begin
                    out_instr_o = in_rdata_i;
                    in_ready_o  = out_ready_i;
                end
            end else if (is_compressed(in_hi)) begin
                out_valid_o = 1'b1;
                out_instr_o = {16'h0000, in_hi};
                in_ready_o  = out_ready_i;
            end else begin
                // Halfword branch target starting a 32-bit instruction: absorb it silently.
                in_ready_o    = 1'b1;
                stash_valid_d = 1'b1;
                stash_d       = '{half: in_hi, addr: in_addr_i, err: 1'b0};
            end
        end

        if (clear_i) begin
            out_valid_o   = 1'b0;
            in_ready_o    = 1'b0;
            stash_valid_d = 1'b0;
        end
    end

    assign out_is_compressed_o = out_instr_o[1:0] != INSTR_UNCOMPRESSED;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stash_valid_q <= 1'b0;
        end else begin
            stash_valid_q <= stash_valid_d;
        end
    end

    generate
        if (ResetAll) begin : g_stash_rst
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    stash_q <= '0;
                end else begin
                    stash_q <= stash_d;
                end
            end
        end else begin : g_stash_norst
            always_ff @(posedge clk_i) begin
                stash_q <= stash_d;
            end
        end
    endgenerate

endmodule
